// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: drives the PC, fetches over a req/gnt + rvalid
// memory handshake (one outstanding request) and hands words to decode over valid/ready.
module instr_fetch #(
  parameter int unsigned          ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       fetch_count
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   pc_inflight_q, pc_inflight_d;
  logic [31:0]         instr_q, instr_d;
  logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;
  logic                instr_valid_q, instr_valid_d;
  logic [31:0]         fetch_count_q, fetch_count_d;
  logic [ADDR_W-1:0]   redirect_tgt;

  assign redirect_tgt = {redirect_pc[ADDR_W-1:2], 2'b00};

  // Request is suppressed during the reset cycle even if the state says REQ.
  assign imem_req    = (state_q == S_REQ) && !rst;
  assign imem_addr   = rst ? RESET_PC : pc_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign instr_pc    = instr_pc_q;
  assign fetch_count = fetch_count_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pc_inflight_d = pc_inflight_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    fetch_count_d = fetch_count_q;
    unique case (state_q)
      S_REQ: begin
        if (redirect) begin
          pc_d = redirect_tgt;
          // A request accepted in the same cycle still owes a response; drop it.
          if (imem_gnt) state_d = S_DROP;
        end else if (imem_gnt) begin
          pc_inflight_d = pc_q;
          pc_d          = pc_q + ADDR_W'(4);
          state_d       = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          pc_d    = redirect_tgt;
          state_d = imem_rvalid ? S_REQ : S_DROP;
        end else if (imem_rvalid) begin
          instr_d       = imem_rdata;
          instr_pc_d    = pc_inflight_q;
          instr_valid_d = 1'b1;
          state_d       = S_HOLD;
        end
      end
      S_DROP: begin
        if (redirect) pc_d = redirect_tgt;
        if (imem_rvalid) state_d = S_REQ;
      end
      S_HOLD: begin
        if (redirect) begin
          instr_valid_d = 1'b0;
          pc_d          = redirect_tgt;
          state_d       = S_REQ;
        end else if (instr_ready) begin
          instr_valid_d = 1'b0;
          fetch_count_d = fetch_count_q + 32'd1;
          state_d       = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  always_ff @(posedge clk) begin
    pc_inflight_q <= pc_inflight_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(imem_rvalid && (state_q == S_REQ || state_q == S_HOLD)))
        else $error("instr_fetch: imem_rvalid with no outstanding request");
      assert (imem_addr[1:0] == 2'b00)
        else $error("instr_fetch: imem_addr not word aligned");
    end
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch sequencer: the producer side of the opcode/instruction interface that the control unit decodes.
- Holds the PC, issues requests to instruction memory over a req/gnt + rvalid handshake, and latches the returned word.
- Presents the word, its opcode field and its PC to the decode stage with a valid/ready handshake.
- Supports one outstanding memory request and control-flow redirects (branch/jump) with in-flight response squash.

Parameters:
ADDR_W, 32, width of PC and instruction memory address
RESET_PC, 32'h0000_0000, PC loaded on reset (bits [1:0] must be 0)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  ADDR_W  fetch address, word aligned
imem_gnt  input  1  memory accepts request when imem_req & imem_gnt
imem_rvalid  input  1  response valid; exactly one per accepted request, in order, at least 1 cycle after gnt
imem_rdata  input  32  instruction word, valid with imem_rvalid
instr_valid  output  1  instruction available to decode
instr_ready  input  1  decode accepts; transfer when instr_valid & instr_ready
instr  output  32  latched instruction word
opcode  output  6  instr[31:26], feeds control unit OpCode
instr_pc  output  ADDR_W  PC of instr
redirect  input  1  load new PC, squash in-flight or held instruction
redirect_pc  input  ADDR_W  redirect target; bits [1:0] forced to 0
fetch_count  output  32  count of instructions handed to decode

Behaviour:
- Reset (rst=1 at edge):
  - state=REQ; pc=RESET_PC.
  - imem_req=0 during the reset cycle; imem_addr=RESET_PC.
  - instr_valid=0, instr=0, instr_pc=0, fetch_count=0.
  - Any prior in-flight response is not tracked; instruction memory shares rst.
- imem_req is a registered-state decode: 1 only in state REQ and not in the reset cycle. imem_addr=pc.
- States REQ, WAIT, HOLD, DROP. Redirect has highest priority in every state.
- REQ:
  - imem_req=1. imem_addr is held stable until gnt, except on redirect.
  - gnt & !redirect -> pc_inflight<=pc, pc<=pc+4 (mod 2^ADDR_W, 0xFFFFFFFC wraps to 0), go WAIT.
  - redirect & !gnt -> pc<=redirect_pc, stay REQ; new address appears next cycle.
  - redirect & gnt -> pc<=redirect_pc, go DROP (the accepted response must be discarded).
- WAIT:
  - imem_req=0.
  - rvalid & !redirect -> instr<=rdata, instr_pc<=pc_inflight, instr_valid<=1, go HOLD.
  - redirect & rvalid -> discard, pc<=redirect_pc, go REQ.
  - redirect & !rvalid -> pc<=redirect_pc, go DROP.
- DROP:
  - imem_req=0. Wait for the squashed response.
  - rvalid -> discard, go REQ. Redirect here only updates pc; stay DROP if !rvalid.
- HOLD:
  - instr_valid=1; instr, opcode and instr_pc are held stable.
  - instr_ready & !redirect -> instr_valid<=0, fetch_count<=fetch_count+1 (wraps), go REQ.
  - redirect (with or without ready) -> instr_valid<=0, not counted, pc<=redirect_pc, go REQ.
- Timing:
  - Minimum latency from gnt to instr_valid is 2 cycles (gnt edge, rvalid edge). Best-case throughput: 1 instruction per 3 cycles.
  - opcode is purely combinational from the instr register; there is no extra latency.
- Assertion checks:
  - imem_rvalid outside WAIT/DROP is a protocol error.
  - imem_addr[1:0] is always 0.

Test Plan:
- Reset, then gnt=1 always, rvalid 1 cycle after gnt, ready=1, memory returns word = 0x8C000000|addr -> instr_pc sequence 0,4,8,…; opcode=6'b100011; fetch_count=3 after 3 transfers; imem_req first high the cycle after rst drops.
- Hold ready=0 for 5 cycles with instr=0x00000020 -> instr_valid, instr and instr_pc stable; no new imem_req; opcode=0; count unchanged until ready=1.
- gnt delayed 3 cycles -> imem_addr stays 0x8 throughout, pc advances only on the gnt edge.
- Redirect to 0x100 in WAIT with rvalid 2 cycles later -> response dropped (no instr_valid), next imem_addr=0x100, instr_pc=0x100.
- Redirect to 0x203 in HOLD with ready=1 same cycle -> instr discarded, fetch_count unchanged, next imem_addr=0x200.
- RESET_PC=0xFFFFFFFC -> first fetch 0xFFFFFFFC, second 0x00000000; rst asserted while in WAIT -> next cycle instr_valid=0, count=0, pc=RESET_PC.
